frame_pose_scorer: RTL and testbench

//  Per-frame pose-match grader placed after the skeleton/distance pipeline.

---
 rtl/frame_pose_scorer.sv | 172 +++++++++++++++++
 tb/tb_frame_pose_scorer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pose_scorer.sv
// Per-frame pose grader: accumulates shifted skeleton distances, grades the mean
// error iteratively into SCORE_LEVELS bins, and offers the grade on valid/ready. Optional BEST_SCORE_EN.
module frame_pose_scorer #(
    parameter int HRES         = 320,
    parameter int VRES         = 180,
    parameter int DIST_WIDTH   = 5,
    parameter int SHIFT        = 2,
    parameter int SCORE_LEVELS = 8,
    localparam int GW          = $clog2(SCORE_LEVELS),
    localparam int CNT_W       = $clog2(HRES*VRES+1)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_start_in,
    input  logic                  valid_in,
    input  logic                  skeleton_bit_in,
    input  logic [DIST_WIDTH-1:0] pixel_distance_in,
    input  logic                  is_last_pixel_in,
    input  logic                  score_ready_in,
    output logic                  score_valid_out,
    output logic [GW-1:0]         score_out,
    output logic [CNT_W-1:0]      skel_count_out,
    output logic                  busy_out
`ifdef BEST_SCORE_EN
    ,
    output logic [GW-1:0]         best_score_out,
    output logic                  best_valid_out
`endif
);

    localparam int ACC_W  = CNT_W + DIST_WIDTH;
    localparam int PROD_W = ACC_W + GW + DIST_WIDTH;
    localparam int MAXP   = ((2**DIST_WIDTH) - 1) >> SHIFT;
    localparam int NPIX   = HRES * VRES;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_GRADE = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GW-1:0]    k_q, k_d;
    logic [GW-1:0]    score_q, score_d;
    logic [CNT_W-1:0] skel_q, skel_d;
    logic             valid_q, valid_d;

    logic [PROD_W-1:0] lhs, rhs;
    logic [GW-1:0]     grade;
    logic              open_frame, take_pixel, resolve, handshake;

    always_comb begin
        // Compare sum*SCORE_LEVELS against count*MAXP*(k+1) at full product width.
        lhs = PROD_W'(sum_q) << GW;
        rhs = PROD_W'(count_q) * PROD_W'(MAXP) * (PROD_W'(k_q) + PROD_W'(1));

        resolve = (MAXP == 0) || (count_q == '0) || (lhs < rhs) ||
                  (k_q == GW'(SCORE_LEVELS - 1));
        if (MAXP == 0)
            grade = '0;
        else if (count_q == '0)
            grade = GW'(SCORE_LEVELS - 1);
        else
            grade = k_q;

        open_frame = frame_start_in && ((state_q == S_IDLE) || (state_q == S_ACCUM));
        take_pixel = valid_in && ((state_q == S_ACCUM) || open_frame);
        handshake  = (state_q == S_OUT) && valid_q && score_ready_in;
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        k_d     = k_q;
        score_d = score_q;
        skel_d  = skel_q;
        valid_d = valid_q;

        // A start in IDLE or ACCUM opens a fresh frame; its own pixel is the first one.
        if (open_frame) begin
            state_d = S_ACCUM;
            sum_d   = '0;
            count_d = '0;
        end
        if (take_pixel && skeleton_bit_in) begin
            sum_d = sum_d + ACC_W'(pixel_distance_in >> SHIFT);
            if (count_d != CNT_W'(NPIX))
                count_d = count_d + CNT_W'(1);
        end
        if (take_pixel && is_last_pixel_in) begin
            state_d = S_GRADE;
            k_d     = '0;
        end

        case (state_q)
            S_GRADE: begin
                if (resolve) begin
                    score_d = grade;
                    skel_d  = count_q;
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end else begin
                    k_d = k_q + GW'(1);
                end
            end
            S_OUT: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    sum_d   = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            count_q <= '0;
            k_q     <= '0;
            score_q <= '0;
            skel_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            k_q     <= k_d;
            score_q <= score_d;
            skel_q  <= skel_d;
            valid_q <= valid_d;
        end
    end

    assign score_valid_out = valid_q;
    assign score_out       = score_q;
    assign skel_count_out  = skel_q;
    assign busy_out        = (state_q != S_IDLE);

`ifdef BEST_SCORE_EN
    logic [GW-1:0] best_q, best_d;
    logic          best_vld_q, best_vld_d;

    always_comb begin
        best_d     = best_q;
        best_vld_d = best_vld_q;
        if (handshake && (!best_vld_q || (score_q < best_q))) begin
            best_d     = score_q;
            best_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            best_q     <= '0;
            best_vld_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            best_vld_q <= best_vld_d;
        end
    end

    assign best_score_out = best_q;
    assign best_valid_out = best_vld_q;
`endif

endmodule

// File: tb/tb_frame_pose_scorer.sv
// Randomized self-checking bench for frame_pose_scorer against a frame-level grading model.
module tb_frame_pose_scorer;

    localparam int DIST_W = 5;
    localparam int SHIFT  = 2;
    localparam int SL     = 8;
    localparam int GW     = 3;
    localparam int CNT_W  = 16;
    localparam int MAXP   = ((2**DIST_W) - 1) >> SHIFT;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              frame_start_in;
    logic              valid_in;
    logic              skeleton_bit_in;
    logic [DIST_W-1:0] pixel_distance_in;
    logic              is_last_pixel_in;
    logic              score_ready_in;
    logic              score_valid_out;
    logic [GW-1:0]     score_out;
    logic [CNT_W-1:0]  skel_count_out;
    logic              busy_out;
`ifdef BEST_SCORE_EN
    logic [GW-1:0]     best_score_out;
    logic              best_valid_out;
`endif

    frame_pose_scorer dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .frame_start_in    (frame_start_in),
        .valid_in          (valid_in),
        .skeleton_bit_in   (skeleton_bit_in),
        .pixel_distance_in (pixel_distance_in),
        .is_last_pixel_in  (is_last_pixel_in),
        .score_ready_in    (score_ready_in),
        .score_valid_out   (score_valid_out),
        .score_out         (score_out),
        .skel_count_out    (skel_count_out),
        .busy_out          (busy_out)
`ifdef BEST_SCORE_EN
        ,
        .best_score_out    (best_score_out),
        .best_valid_out    (best_valid_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    int fr_dist[$];
    bit fr_skel[$];
    bit fr_start[$];

    int best_m;
    bit best_v_m;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Grade = smallest k whose threshold the mean error stays under, else the worst bin.
    function automatic int model_grade(input int s, input int c);
        if (MAXP == 0) return 0;
        if (c == 0) return SL - 1;
        for (int k = 0; k < SL; k++)
            if (s * SL < c * MAXP * (k + 1)) return k;
        return SL - 1;
    endfunction

    task automatic clear_inputs();
        frame_start_in    = 1'b0;
        valid_in          = 1'b0;
        skeleton_bit_in   = 1'b0;
        pixel_distance_in = '0;
        is_last_pixel_in  = 1'b0;
        score_ready_in    = 1'b0;
    endtask

    task automatic noise(input bit allow_start);
        frame_start_in    = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
        valid_in          = 1'($urandom_range(0, 1));
        skeleton_bit_in   = 1'($urandom_range(0, 1));
        pixel_distance_in = DIST_W'($urandom_range(0, 31));
        is_last_pixel_in  = 1'($urandom_range(0, 1));
    endtask

    task automatic new_frame();
        fr_dist.delete();
        fr_skel.delete();
        fr_start.delete();
    endtask

    task automatic add_px(input bit st, input bit sk, input int d);
        fr_start.push_back(st);
        fr_skel.push_back(sk);
        fr_dist.push_back(d);
    endtask

    task automatic drive_pixels();
        for (int i = 0; i < fr_dist.size(); i++) begin
            if (i > 0) begin
                while ($urandom_range(0, 3) == 0) begin
                    noise(1'b0);
                    valid_in = 1'b0;
                    tick();
                end
            end
            frame_start_in    = fr_start[i];
            valid_in          = 1'b1;
            skeleton_bit_in   = fr_skel[i];
            pixel_distance_in = DIST_W'(fr_dist[i]);
            is_last_pixel_in  = (i == fr_dist.size() - 1);
            tick();
        end
    endtask

    task automatic run_frame(input string tag, input int hold);
        int s, c, g, lat, exp_lat;
        s = 0;
        c = 0;
        foreach (fr_dist[i]) begin
            if (fr_start[i]) begin
                s = 0;
                c = 0;
            end
            if (fr_skel[i]) begin
                s += fr_dist[i] >> SHIFT;
                c++;
            end
        end
        g = model_grade(s, c);
        exp_lat = (c == 0) ? 2 : g + 2;

        drive_pixels();
        lat = 1;
        while (!score_valid_out && lat < 20) begin
            noise(1'b1);
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_score"}, score_out, g);
        check_eq({tag, "_count"}, skel_count_out, c);
        check_eq({tag, "_busy"}, busy_out, 1);

        for (int h = 0; h < hold; h++) begin
            noise(1'b1);
            score_ready_in = 1'b0;
            tick();
            check_eq({tag, "_hold_valid"}, score_valid_out, 1);
            check_eq({tag, "_hold_score"}, score_out, g);
            check_eq({tag, "_hold_busy"}, busy_out, 1);
        end

        noise(1'b1);
        score_ready_in = 1'b1;
        tick();
        clear_inputs();
        if (!best_v_m || g < best_m) begin
            best_m   = g;
            best_v_m = 1'b1;
        end
        check_eq({tag, "_post_valid"}, score_valid_out, 0);
        check_eq({tag, "_post_busy"}, busy_out, 0);
`ifdef BEST_SCORE_EN
        check_eq({tag, "_best_valid"}, best_valid_out, 1);
        check_eq({tag, "_best_score"}, best_score_out, best_m);
`endif

        for (int n = $urandom_range(0, 3); n > 0; n--) begin
            noise(1'b0);
            tick();
        end
        clear_inputs();
    endtask

    task automatic uniform_frame(input int n, input int d);
        new_frame();
        for (int i = 0; i < n; i++) add_px(i == 0, 1'b1, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        best_m   = 0;
        best_v_m = 1'b0;
        rst_in   = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", score_valid_out, 0);
        check_eq("rst_score", score_out, 0);
        check_eq("rst_count", skel_count_out, 0);
        check_eq("rst_busy", busy_out, 0);
`ifdef BEST_SCORE_EN
        check_eq("rst_best_valid", best_valid_out, 0);
        check_eq("rst_best_score", best_score_out, 0);
`endif
        rst_in = 1'b0;
        tick();

        uniform_frame(4, 31);
        run_frame("d31x4", 1);
        uniform_frame(4, 0);
        run_frame("d0x4", 0);

        new_frame();
        for (int i = 0; i < 5; i++) add_px(i == 0, 1'b0, 31);
        run_frame("noskel", 0);

        uniform_frame(4, 12);
        run_frame("d12x4", 10);

        new_frame();
        for (int i = 0; i < 3; i++) add_px(i == 0, 1'b1, 31);
        add_px(1'b1, 1'b1, 0);
        add_px(1'b0, 1'b1, 0);
        run_frame("restart", 2);

        // Fresh best tracking for the 5,2,6 grade sequence.
        rst_in = 1'b1;
        tick();
        rst_in   = 1'b0;
        best_v_m = 1'b0;
        best_m   = 0;
        tick();
        uniform_frame(4, 20);
        run_frame("g5", 0);
        uniform_frame(4, 8);
        run_frame("g2", 0);
        uniform_frame(4, 24);
        run_frame("g6", 0);

        uniform_frame(4, 31);
        drive_pixels();
        clear_inputs();
        tick();
        check_eq("midgrade_busy", busy_out, 1);
        rst_in = 1'b1;
        #1;
        check_eq("midgrade_rst_valid", score_valid_out, 0);
        check_eq("midgrade_rst_busy", busy_out, 0);
        best_v_m = 1'b0;
        best_m   = 0;
`ifdef BEST_SCORE_EN
        check_eq("midgrade_rst_best", best_valid_out, 0);
`endif
        tick();
        rst_in = 1'b0;
        check_eq("midgrade_rst_count", skel_count_out, 0);
        tick();

        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(2, 30);
            new_frame();
            for (int i = 0; i < len; i++)
                add_px((i == 0) || ($urandom_range(0, 14) == 0),
                       1'($urandom_range(0, 1)), $urandom_range(0, 31));
            run_frame($sformatf("rnd%0d", f), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
